// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: turns one pixel vector per window into rate-coded
// spike trains. Each channel adds its pixel value into a phase accumulator
// every issued timestep. The carry out of that addition is the spike, so
// channel i fires floor(pixel_i * WINDOW_LEN / 2^PIXEL_WIDTH) times per window.
// A neuron_rst pulse precedes every window, so downstream neurons start clean.
module spike_rate_encoder #(
   parameter int NUM_INPUTS  = 4,
   parameter int PIXEL_WIDTH = 8,
   parameter int WINDOW_LEN  = 256
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              pixel_valid,
   output logic                              pixel_ready,
   input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_data,
   input  logic                              step_en,
   output logic [NUM_INPUTS-1:0]             spike_out,
   output logic                              spike_valid,
   output logic                              neuron_rst,
   output logic                              window_done,
   output logic [15:0]                       step_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [15:0] WINDOW_LEN_C = 16'(WINDOW_LEN);

   state_t                                   state_q, state_d;
   logic [NUM_INPUTS*PIXEL_WIDTH-1:0]        pix_q, pix_d;
   logic [NUM_INPUTS-1:0][PIXEL_WIDTH-1:0]   acc_q, acc_d;
   logic [NUM_INPUTS-1:0]                    spike_out_q, spike_out_d;
   logic                                     spike_valid_q, spike_valid_d;
   logic                                     neuron_rst_q, neuron_rst_d;
   logic                                     window_done_q, window_done_d;
   logic                                     pixel_ready_q, pixel_ready_d;
   logic [15:0]                              step_count_q, step_count_d;
   logic [PIXEL_WIDTH:0]                     sum_s [NUM_INPUTS];

   // Per-channel accumulator plus pixel, one bit wider so the carry is the spike.
   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         sum_s[i] = {1'b0, acc_q[i]} + {1'b0, pix_q[i*PIXEL_WIDTH +: PIXEL_WIDTH]};
      end
   end

   // Next-state and next-output logic. Pulse outputs default low every cycle.
   always_comb begin
      state_d       = state_q;
      pix_d         = pix_q;
      acc_d         = acc_q;
      step_count_d  = step_count_q;
      spike_out_d   = '0;
      spike_valid_d = 1'b0;
      neuron_rst_d  = 1'b0;
      window_done_d = 1'b0;
      pixel_ready_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pixel_valid && pixel_ready_q) begin
               pix_d        = pixel_data;
               acc_d        = '0;
               step_count_d = 16'd0;
               neuron_rst_d = 1'b1;
               state_d      = ST_RUN;
            end else begin
               pixel_ready_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (step_en) begin
               for (int i = 0; i < NUM_INPUTS; i++) begin
                  acc_d[i]       = sum_s[i][PIXEL_WIDTH-1:0];
                  spike_out_d[i] = sum_s[i][PIXEL_WIDTH];
               end
               spike_valid_d = 1'b1;
               step_count_d  = step_count_q + 16'd1;
               // The last step of the window shows its spikes together with window_done.
               if ((step_count_q + 16'd1) == WINDOW_LEN_C) begin
                  window_done_d = 1'b1;
                  state_d       = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d       = ST_IDLE;
            pixel_ready_d = 1'b1;
         end
         default: begin
            state_d       = ST_IDLE;
            pixel_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers. Reset wins over every other update, including mid-window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pix_q         <= '0;
         acc_q         <= '0;
         step_count_q  <= 16'd0;
         spike_out_q   <= '0;
         spike_valid_q <= 1'b0;
         neuron_rst_q  <= 1'b0;
         window_done_q <= 1'b0;
         pixel_ready_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         pix_q         <= pix_d;
         acc_q         <= acc_d;
         step_count_q  <= step_count_d;
         spike_out_q   <= spike_out_d;
         spike_valid_q <= spike_valid_d;
         neuron_rst_q  <= neuron_rst_d;
         window_done_q <= window_done_d;
         pixel_ready_q <= pixel_ready_d;
      end
   end

   assign pixel_ready = pixel_ready_q;
   assign spike_out   = spike_out_q;
   assign spike_valid = spike_valid_q;
   assign neuron_rst  = neuron_rst_q;
   assign window_done = window_done_q;
   assign step_count  = step_count_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder. Inputs are driven and outputs are sampled on the
// falling edge. Expected spikes come from the closed-form rate rule: a channel
// with pixel p spikes on step k when floor((k+1)p/2^W) exceeds floor(kp/2^W).
module tb_spike_rate_encoder;

   localparam int NI  = 4;
   localparam int PW  = 8;
   localparam int WL  = 256;
   localparam int WL2 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             pixel_valid;
   logic             pixel_ready;
   logic [NI*PW-1:0] pixel_data;
   logic             step_en;
   logic [NI-1:0]    spike_out;
   logic             spike_valid;
   logic             neuron_rst;
   logic             window_done;
   logic [15:0]      step_count;

   logic             pixel_valid2;
   logic             pixel_ready2;
   logic [PW-1:0]    pixel_data2;
   logic             step_en2;
   logic [0:0]       spike_out2;
   logic             spike_valid2;
   logic             neuron_rst2;
   logic             window_done2;
   logic [15:0]      step_count2;

   int checks = 0;
   int errors = 0;

   spike_rate_encoder #(.NUM_INPUTS(NI), .PIXEL_WIDTH(PW), .WINDOW_LEN(WL)) u_dut (
      .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .pixel_data(pixel_data), .step_en(step_en), .spike_out(spike_out),
      .spike_valid(spike_valid), .neuron_rst(neuron_rst), .window_done(window_done),
      .step_count(step_count)
   );

   spike_rate_encoder #(.NUM_INPUTS(1), .PIXEL_WIDTH(PW), .WINDOW_LEN(WL2)) u_dut16 (
      .clk(clk), .rst(rst), .pixel_valid(pixel_valid2), .pixel_ready(pixel_ready2),
      .pixel_data(pixel_data2), .step_en(step_en2), .spike_out(spike_out2),
      .spike_valid(spike_valid2), .neuron_rst(neuron_rst2), .window_done(window_done2),
      .step_count(step_count2)
   );

   // Count one comparison and report it if it does not match.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit ref_spike(input int p, input int k, input int w);
      return (((k + 1) * p) >> w) != ((k * p) >> w);
   endfunction

   function automatic int pix_of(input logic [NI*PW-1:0] vec, input int i);
      logic [PW-1:0] v;
      v = vec[i*PW +: PW];
      return int'(v);
   endfunction

   // Present a vector in IDLE and check the acceptance cycle that follows.
   task automatic accept(input logic [NI*PW-1:0] vec, input bit hold, input logic [NI*PW-1:0] hold_vec);
      pixel_data  = vec;
      pixel_valid = 1'b1;
      check_val("ready_before_accept", 32'(pixel_ready), 32'd1);
      @(negedge clk);
      check_val("neuron_rst_pulse", 32'(neuron_rst), 32'd1);
      check_val("ready_after_accept", 32'(pixel_ready), 32'd0);
      check_val("step_count_cleared", 32'(step_count), 32'd0);
      check_val("no_spike_in_rst_cycle", 32'(spike_valid), 32'd0);
      if (hold) begin
         pixel_data = hold_vec;
      end else begin
         pixel_valid = 1'b0;
      end
   endtask

   // Issue steps (0: always, 1: alternate, 2: random) and check every cycle.
   task automatic run_window(input logic [NI*PW-1:0] vec, input int mode, input int abort_at);
      int k;
      int guard;
      int cnt [NI];
      bit en;
      logic [NI-1:0] exp_s;
      k = 0;
      guard = 0;
      for (int i = 0; i < NI; i++) cnt[i] = 0;
      while (k < WL && guard < 4*WL + 16) begin
         if (abort_at >= 0 && k == abort_at) break;
         case (mode)
            0:       en = 1'b1;
            1:       en = (guard % 2 == 0);
            default: en = ($urandom_range(0, 3) != 0);
         endcase
         step_en = en;
         @(negedge clk);
         guard++;
         if (en) begin
            for (int i = 0; i < NI; i++) begin
               exp_s[i] = ref_spike(pix_of(vec, i), k, PW);
               cnt[i] += int'(spike_out[i]);
            end
            check_val("spike_valid_step", 32'(spike_valid), 32'd1);
            check_val("spike_out_step", 32'(spike_out), 32'(exp_s));
            check_val("step_count_step", 32'(step_count), 32'(k + 1));
            check_val("window_done_step", 32'(window_done), 32'(k + 1 == WL));
            check_val("neuron_rst_quiet", 32'(neuron_rst), 32'd0);
            k++;
         end else begin
            check_val("spike_valid_stall", 32'(spike_valid), 32'd0);
            check_val("spike_out_stall", 32'(spike_out), 32'd0);
            check_val("step_count_stall", 32'(step_count), 32'(k));
            check_val("window_done_stall", 32'(window_done), 32'd0);
         end
         check_val("ready_in_run", 32'(pixel_ready), 32'd0);
      end
      step_en = 1'b0;
      if (abort_at < 0) begin
         check_val("window_steps_issued", 32'(k), 32'(WL));
         for (int i = 0; i < NI; i++) begin
            check_val("spike_total", 32'(cnt[i]), 32'((pix_of(vec, i) * WL) >> PW));
         end
         @(negedge clk);
         check_val("ready_after_done", 32'(pixel_ready), 32'd1);
         check_val("idle_spike_valid", 32'(spike_valid), 32'd0);
         check_val("idle_spike_out", 32'(spike_out), 32'd0);
         check_val("idle_window_done", 32'(window_done), 32'd0);
         check_val("step_count_saturated", 32'(step_count), 32'(WL));
      end
   endtask

   initial begin
      logic [NI*PW-1:0] va;
      logic [NI*PW-1:0] vb;
      int cnt2;
      rst          = 1'b1;
      pixel_valid  = 1'b0;
      pixel_data   = '0;
      step_en      = 1'b0;
      pixel_valid2 = 1'b0;
      pixel_data2  = '0;
      step_en2     = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_ready", 32'(pixel_ready), 32'd1);
      check_val("reset_spike_valid", 32'(spike_valid), 32'd0);
      check_val("reset_spike_out", 32'(spike_out), 32'd0);
      check_val("reset_neuron_rst", 32'(neuron_rst), 32'd0);
      check_val("reset_window_done", 32'(window_done), 32'd0);
      check_val("reset_step_count", 32'(step_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Channels 0..3 carry pixels 0, 1, 128, 255.
      va = {8'd255, 8'd128, 8'd1, 8'd0};
      accept(va, 1'b0, va);
      run_window(va, 0, -1);

      // pixel_valid stays high through the whole window with a different vector.
      va = {8'd17, 8'd200, 8'd3, 8'd90};
      vb = $urandom();
      accept(va, 1'b1, vb);
      run_window(va, 0, -1);
      accept(vb, 1'b0, vb);
      run_window(vb, 2, -1);

      // Alternating stalls.
      va = {4{8'd64}};
      accept(va, 1'b0, va);
      run_window(va, 1, -1);

      // Reset at step 100, then a full-scale window.
      va = {8'd33, 8'd77, 8'd250, 8'd5};
      accept(va, 1'b0, va);
      run_window(va, 0, 100);
      check_val("abort_step_count", 32'(step_count), 32'd100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("abort_spike_valid", 32'(spike_valid), 32'd0);
      check_val("abort_spike_out", 32'(spike_out), 32'd0);
      check_val("abort_window_done", 32'(window_done), 32'd0);
      check_val("abort_step_count_clr", 32'(step_count), 32'd0);
      check_val("abort_ready", 32'(pixel_ready), 32'd1);
      @(negedge clk);
      check_val("abort_no_done_later", 32'(window_done), 32'd0);
      check_val("abort_ready_hold", 32'(pixel_ready), 32'd1);
      va = {4{8'd255}};
      accept(va, 1'b0, va);
      run_window(va, 0, -1);

      // Random vectors with random stalls.
      for (int w = 0; w < 4; w++) begin
         va = $urandom();
         accept(va, 1'b0, va);
         run_window(va, 2, -1);
      end

      // Short window instance: WINDOW_LEN=16, pixel 200 gives 12 spikes.
      check_val("w16_ready", 32'(pixel_ready2), 32'd1);
      pixel_valid2 = 1'b1;
      pixel_data2  = 8'd200;
      @(negedge clk);
      pixel_valid2 = 1'b0;
      check_val("w16_neuron_rst", 32'(neuron_rst2), 32'd1);
      cnt2 = 0;
      for (int k = 0; k < WL2; k++) begin
         step_en2 = 1'b1;
         @(negedge clk);
         cnt2 += int'(spike_out2);
         check_val("w16_spike", 32'(spike_out2), 32'(ref_spike(200, k, PW)));
         check_val("w16_valid", 32'(spike_valid2), 32'd1);
         check_val("w16_done", 32'(window_done2), 32'(k == WL2 - 1));
      end
      step_en2 = 1'b0;
      check_val("w16_total", 32'(cnt2), 32'd12);
      @(negedge clk);
      check_val("w16_ready_after", 32'(pixel_ready2), 32'd1);
      check_val("w16_count_hold", 32'(step_count2), 32'(WL2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so a stuck run still ends.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Upstream stage of if_neuron: converts a vector of pixel intensities into deterministic rate-coded spike trains on the neuron's spike_in bus, one timestep per enabled clock.
- Each channel uses a phase accumulator. Over a full window of 2^PIXEL_WIDTH timesteps, channel i emits exactly pixel_i spikes.
- Accepts one pixel vector per window via valid/ready. Pulses neuron_rst so downstream neurons clear their potentials before each new window.

Parameters:
- NUM_INPUTS, 4: channel count; matches the downstream neuron's NUM_INPUTS.
- PIXEL_WIDTH, 8: intensity bits per channel.
- WINDOW_LEN, 256: timesteps per window; range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pixel_valid  input  1  pixel_data is valid.
- pixel_ready  output  1  encoder can accept a vector (high only in IDLE).
- pixel_data  input  NUM_INPUTS*PIXEL_WIDTH  channel i = bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- step_en  input  1  advance one timestep this cycle; low = stall.
- spike_out  output  NUM_INPUTS  spike vector for the current timestep; drives neuron spike_in.
- spike_valid  output  1  spike_out holds a new timestep this cycle.
- neuron_rst  output  1  one-cycle pulse at window start; drives neuron rst.
- window_done  output  1  one-cycle pulse after the last timestep of a window.
- step_count  output  16  timesteps issued in the current window.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All accumulators, latched pixels, step_count = 0.
  - spike_out=0, spike_valid=0, neuron_rst=0, window_done=0, pixel_ready=1 from the next cycle.
  - Reset overrides everything in the same cycle, including a mid-window reset. A window aborted by reset produces no window_done.
- States: IDLE, RUN, DONE.
- IDLE:
  - pixel_ready=1.
  - On pixel_valid & pixel_ready: latch all pixels, clear accumulators and step_count, assert neuron_rst for exactly the next cycle, go to RUN.
- RUN:
  - pixel_ready=0; pixel_valid is ignored.
  - Per cycle with step_en=1, for each i: sum = {1'b0, acc_i} + pixel_i, computed in PIXEL_WIDTH+1 bits.
  - acc_i <= sum[PIXEL_WIDTH-1:0]; spike_out[i] <= sum[PIXEL_WIDTH].
  - spike_valid <= 1; step_count increments.
  - Latency: the spike for a step accepted at edge N is visible after edge N, for one cycle.
  - With step_en=0: accumulators and step_count hold; spike_out <= 0, spike_valid <= 0.
  - step_en during the neuron_rst cycle is legal and counts as step 0.
  - When the step that makes step_count == WINDOW_LEN is issued, go to DONE.
- DONE:
  - window_done=1 for one cycle, while spike_out/spike_valid present the final step.
  - Then return to IDLE.
  - Back-to-back windows: a new vector may be accepted the cycle after DONE.
- Arithmetic:
  - The accumulator wraps modulo 2^PIXEL_WIDTH; spike = carry out.
  - pixel=0: never spikes.
  - pixel=2^PIXEL_WIDTH-1: spikes every step except the first.
  - Spike count per window = floor(pixel*WINDOW_LEN / 2^PIXEL_WIDTH).
- spike_out is never nonzero while spike_valid=0.
- step_count saturates at WINDOW_LEN and holds until the next acceptance.

Test Plan:
- Reset then pixels {0,1,128,255}, step_en=1 for 256 cycles -> per-channel spike counts {0,1,128,255}. Ch1 spikes only on step 255; ch2 spikes on odd steps 1,3,...,255. window_done pulses exactly once, in the cycle showing step 255.
- Handshake: pixel_valid held high through RUN -> second vector accepted only after DONE. neuron_rst pulses exactly once per acceptance, one cycle after it. pixel_ready=0 throughout RUN.
- Stall: pixel {64,...}; toggle step_en 1/0 every cycle -> 64 spikes over 256 issued steps. spike_valid=0 and spike_out=0 on stalled cycles; step_count frozen during stalls.
- Reset mid-window at step 100 -> outputs 0 next cycle, no window_done, pixel_ready=1. A fresh vector {255,...} then gives 255 spikes.
- WINDOW_LEN=16, PIXEL_WIDTH=8, pixel 200 -> 12 spikes (floor(200*16/256)=12); window_done after step 15.
- Integration with if_neuron (THRESH=10, unit weights): pixel {3,3,3,3}, window 256 -> neuron spike_out asserts once cumulative spikes reach 10. Potential clears on the neuron_rst of the next window.
